// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter: widths, buffered-entry layout
// and a one-hot register decoder.
package wb_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_FIFO,
        SRC_BYPASS
    } wb_src_t;

    function automatic logic [31:0] onehot32(input logic [REG_AW-1:0] waddr);
        logic [31:0] bits;
        bits = '0;
        bits[waddr] = 1'b1;
        return bits;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for long-unit results. Entries can be invalidated in place by address;
// invalid entries still occupy a slot until popped. Also keeps the registered pending mask.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [REG_AW-1:0]          push_waddr_i,
    input  logic [DATA_W-1:0]          push_wdata_i,
    input  logic                       pop_i,
    input  logic                       kill_i,
    input  logic [REG_AW-1:0]          kill_addr_i,
    output logic                       head_valid_o,
    output logic [REG_AW-1:0]          head_waddr_o,
    output logic [DATA_W-1:0]          head_wdata_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [31:0]                mask_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t       mem_q [DEPTH];
    wb_entry_t       mem_d [DEPTH];
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     mask_q, mask_d;

    // Kill first, then retire the popped slot, then write the new entry: a push into a
    // full buffer with a coincident pop reuses the slot that is leaving.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_i && mem_q[i].valid && mem_q[i].waddr == kill_addr_i) begin
                mem_d[i].valid = 1'b0;
            end
        end
        if (pop_i) begin
            mem_d[rd_q].valid = 1'b0;
        end
        if (push_i) begin
            mem_d[wr_q] = '{valid: 1'b1, waddr: push_waddr_i, wdata: push_wdata_i};
        end
        rd_d    = pop_i  ? rd_q + 1'b1 : rd_q;
        wr_d    = push_i ? wr_q + 1'b1 : wr_q;
        count_d = count_q + CW'(push_i) - CW'(pop_i);
        mask_d  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_d[i].valid) begin
                mask_d = mask_d | onehot32(mem_d[i].waddr);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            mask_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            mask_q  <= mask_d;
        end
    end

    assign head_valid_o = mem_q[rd_q].valid;
    assign head_waddr_o = mem_q[rd_q].waddr;
    assign head_wdata_o = mem_q[rd_q].wdata;
    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == CW'(DEPTH));
    assign count_o      = count_q;
    assign mask_o       = mask_q;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB always wins, long-unit results bypass or
// queue. Optional head-starvation guard enabled by defining WB_STARVE_GUARD_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       pipe_we_i,
    input  logic [4:0]                 pipe_waddr_i,
    input  logic [31:0]                pipe_wdata_i,
    input  logic                       lu_valid_i,
    output logic                       lu_ready_o,
    input  logic [4:0]                 lu_waddr_i,
    input  logic [31:0]                lu_wdata_i,
    output logic                       rf_we_o,
    output logic [4:0]                 rf_waddr_o,
    output logic [31:0]                rf_wdata_o,
    output logic [31:0]                pend_mask_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       pipe_stall_o
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("wb_arbiter: DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
    end

    logic        pipeBusy;
    logic        fifoEmpty, fifoFull;
    logic        headValid;
    logic [4:0]  headWaddr;
    logic [31:0] headWdata;
    logic        pop, push, kill, bypass;
    logic        luFire, luKilled;
    wb_src_t     src;

    assign pipeBusy   = pipe_we_i && (pipe_waddr_i != '0);
    assign pop        = !rst_i && !pipeBusy && !fifoEmpty;
    assign lu_ready_o = !rst_i && (!fifoFull || pop);
    assign luFire     = lu_valid_i && lu_ready_o;
    // A same-cycle pipe write to the same register is younger, so the lu result is dead.
    assign luKilled   = pipeBusy && (lu_waddr_i == pipe_waddr_i);
    assign bypass     = luFire && !pipeBusy && fifoEmpty && (lu_waddr_i != '0);
    assign push       = luFire && !luKilled && (lu_waddr_i != '0) && (pipeBusy || !fifoEmpty);
    assign kill       = !rst_i && pipeBusy;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push),
        .push_waddr_i (lu_waddr_i),
        .push_wdata_i (lu_wdata_i),
        .pop_i        (pop),
        .kill_i       (kill),
        .kill_addr_i  (pipe_waddr_i),
        .head_valid_o (headValid),
        .head_waddr_o (headWaddr),
        .head_wdata_o (headWdata),
        .empty_o      (fifoEmpty),
        .full_o       (fifoFull),
        .count_o      (count_o),
        .mask_o       (pend_mask_o)
    );

    // A popped killed head yields an empty slot rather than letting the next entry advance.
    always_comb begin
        src = SRC_NONE;
        if (rst_i) begin
            src = SRC_NONE;
        end else if (pipeBusy) begin
            src = SRC_PIPE;
        end else if (!fifoEmpty) begin
            src = headValid ? SRC_FIFO : SRC_NONE;
        end else if (bypass) begin
            src = SRC_BYPASS;
        end
    end

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        unique case (src)
            SRC_PIPE: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = pipe_waddr_i;
                rf_wdata_o = pipe_wdata_i;
            end
            SRC_FIFO: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = headWaddr;
                rf_wdata_o = headWdata;
            end
            SRC_BYPASS: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = lu_waddr_i;
                rf_wdata_o = lu_wdata_i;
            end
            default: begin
                rf_we_o = 1'b0;
            end
        endcase
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int AW = $clog2(STARVE_LIMIT + 1);

    logic [AW-1:0] age_q, age_d;
    logic          stall_q, stall_d;

    always_comb begin
        age_d = '0;
        if (!fifoEmpty && !pop && headValid) begin
            age_d = (age_q == AW'(STARVE_LIMIT)) ? age_q : age_q + 1'b1;
        end
        stall_d = (age_d == AW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            age_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            age_q   <= age_d;
            stall_q <= stall_d;
        end
    end

    assign pipe_stall_o = stall_q && !rst_i;
`else
    assign pipe_stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboarded bench for wb_arbiter: expected regfile writes are queued by the stimulus
// and retired by an independent write monitor; status outputs are checked directly.
module tb_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pipe_we_i;
    logic [4:0]  pipe_waddr_i;
    logic [31:0] pipe_wdata_i;
    logic        lu_valid_i;
    logic        lu_ready_o;
    logic [4:0]  lu_waddr_i;
    logic [31:0] lu_wdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [31:0] pend_mask_o;
    logic [1:0]  count_o;
    logic        pipe_stall_o;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wr_t;

    wr_t expQ [$];
    int  assertCount = 0;
    int  failCount   = 0;

`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pipe_we_i    (pipe_we_i),
        .pipe_waddr_i (pipe_waddr_i),
        .pipe_wdata_i (pipe_wdata_i),
        .lu_valid_i   (lu_valid_i),
        .lu_ready_o   (lu_ready_o),
        .lu_waddr_i   (lu_waddr_i),
        .lu_wdata_i   (lu_wdata_i),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .pend_mask_o  (pend_mask_o),
        .count_o      (count_o),
        .pipe_stall_o (pipe_stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic applyStimulus(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                                 input logic lv, input logic [4:0] la, input logic [31:0] ld);
        pipe_we_i    = pwe;
        pipe_waddr_i = pa;
        pipe_wdata_i = pd;
        lu_valid_i   = lv;
        lu_waddr_i   = la;
        lu_wdata_i   = ld;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.waddr = a;
        w.wdata = d;
        expQ.push_back(w);
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkStatus(input string tag, input logic [1:0] cnt, input logic [31:0] mask);
        checkOutput({tag, ".count"}, 32'(count_o), 32'(cnt));
        checkOutput({tag, ".mask"}, pend_mask_o, mask);
    endtask

    // Write monitor: every regfile write must match the oldest expected write.
    always @(negedge clk_i) begin
        if (!rst_i && rf_we_o) begin
            assertCount++;
            if (expQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL unexpectedWrite: got r%0d=0x%0h, required no write",
                         rf_waddr_o, rf_wdata_o);
            end else begin
                wr_t w;
                w = expQ.pop_front();
                if (rf_waddr_o !== w.waddr || rf_wdata_o !== w.wdata) begin
                    failCount++;
                    $display("[TB] FAIL rfWrite: got r%0d=0x%0h, required r%0d=0x%0h",
                             rf_waddr_o, rf_wdata_o, w.waddr, w.wdata);
                end
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        nextCycle();
        nextCycle();

        // Reset: outputs forced quiet even with requests present
        applyStimulus(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66);
        @(negedge clk_i);
        checkOutput("rst.rfWe", 32'(rf_we_o), 32'h0);
        checkOutput("rst.luReady", 32'(lu_ready_o), 32'h0);
        checkOutput("rst.stall", 32'(pipe_stall_o), 32'h0);
        checkStatus("rst", 2'd0, 32'h0);
        nextCycle();
        rst_i = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        nextCycle();

        // Pipe only
        applyStimulus(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
        expectWrite(5'd5, 32'h11);
        @(negedge clk_i);
        checkOutput("pipe.rfWe", 32'(rf_we_o), 32'h1);
        checkOutput("pipe.luReady", 32'(lu_ready_o), 32'h1);
        checkStatus("pipe", 2'd0, 32'h0);
        nextCycle();

        // Bypass
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hAB);
        expectWrite(5'd7, 32'hAB);
        @(negedge clk_i);
        checkOutput("bypass.luReady", 32'(lu_ready_o), 32'h1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk_i);
        checkOutput("bypass.idleWe", 32'(rf_we_o), 32'h0);
        checkStatus("bypass", 2'd0, 32'h0);
        nextCycle();

        // Buffering behind a busy pipe, full back-pressure, in-order drain
        applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h33);
        expectWrite(5'd10, 32'hA0);
        @(negedge clk_i);
        checkOutput("buf1.luReady", 32'(lu_ready_o), 32'h1);
        nextCycle();
        applyStimulus(1'b1, 5'd11, 32'hA1, 1'b1, 5'd4, 32'h44);
        expectWrite(5'd11, 32'hA1);
        @(negedge clk_i);
        checkStatus("buf2", 2'd1, 32'h08);
        nextCycle();
        applyStimulus(1'b1, 5'd12, 32'hA2, 1'b1, 5'd6, 32'h66);
        expectWrite(5'd12, 32'hA2);
        @(negedge clk_i);
        checkOutput("buf3.luReady", 32'(lu_ready_o), 32'h0);
        checkStatus("buf3", 2'd2, 32'h18);
        nextCycle();
        applyStimulus(1'b1, 5'd13, 32'hA3, 1'b1, 5'd6, 32'h66);
        expectWrite(5'd13, 32'hA3);
        @(negedge clk_i);
        checkOutput("buf4.luReady", 32'(lu_ready_o), 32'h0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66);
        expectWrite(5'd3, 32'h33);
        @(negedge clk_i);
        checkOutput("buf5.luReady", 32'(lu_ready_o), 32'h1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expectWrite(5'd4, 32'h44);
        @(negedge clk_i);
        checkStatus("buf6", 2'd2, 32'h50);
        nextCycle();
        expectWrite(5'd6, 32'h66);
        @(negedge clk_i);
        checkStatus("buf7", 2'd1, 32'h40);
        nextCycle();
        @(negedge clk_i);
        checkStatus("buf8", 2'd0, 32'h0);
        nextCycle();

        // WAW kill of a buffered head; the killed slot produces an empty write cycle
        applyStimulus(1'b1, 5'd20, 32'hB0, 1'b1, 5'd9, 32'h1);
        expectWrite(5'd20, 32'hB0);
        nextCycle();
        applyStimulus(1'b1, 5'd21, 32'hB1, 1'b1, 5'd8, 32'h88);
        expectWrite(5'd21, 32'hB1);
        nextCycle();
        applyStimulus(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'h0);
        expectWrite(5'd9, 32'h2);
        @(negedge clk_i);
        checkStatus("waw1", 2'd2, 32'h300);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk_i);
        checkOutput("waw2.killedSlotWe", 32'(rf_we_o), 32'h0);
        checkStatus("waw2", 2'd2, 32'h100);
        nextCycle();
        expectWrite(5'd8, 32'h88);
        @(negedge clk_i);
        checkStatus("waw3", 2'd1, 32'h100);
        nextCycle();
        @(negedge clk_i);
        checkStatus("waw4", 2'd0, 32'h0);
        nextCycle();

        // Same-cycle lu result to the pipe's register is accepted and dropped
        applyStimulus(1'b1, 5'd9, 32'h3, 1'b1, 5'd9, 32'h5);
        expectWrite(5'd9, 32'h3);
        @(negedge clk_i);
        checkOutput("wawSame.luReady", 32'(lu_ready_o), 32'h1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk_i);
        checkStatus("wawSame", 2'd0, 32'h0);
        nextCycle();

        // r0: lu result discarded, pipe r0 write frees the slot for the head
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hEE);
        @(negedge clk_i);
        checkOutput("r0.luReady", 32'(lu_ready_o), 32'h1);
        checkOutput("r0.rfWe", 32'(rf_we_o), 32'h0);
        nextCycle();
        applyStimulus(1'b1, 5'd22, 32'hC0, 1'b1, 5'd12, 32'hC);
        expectWrite(5'd22, 32'hC0);
        @(negedge clk_i);
        checkStatus("r0a", 2'd0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0);
        expectWrite(5'd12, 32'hC);
        @(negedge clk_i);
        checkStatus("r0b", 2'd1, 32'h1000);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk_i);
        checkStatus("r0c", 2'd0, 32'h0);
        nextCycle();

        // Starvation: head waits behind a continuously busy pipe
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 5'd23, 32'(i), (i == 1), 5'd14, 32'hE);
            expectWrite(5'd23, 32'(i));
            @(negedge clk_i);
            checkOutput($sformatf("starve%0d.stall", i), 32'(pipe_stall_o),
                        32'(GUARD && i >= 10));
            nextCycle();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expectWrite(5'd14, 32'hE);
        @(negedge clk_i);
        checkOutput("starveBubble.stall", 32'(pipe_stall_o), 32'(GUARD));
        nextCycle();
        @(negedge clk_i);
        checkOutput("starveDone.stall", 32'(pipe_stall_o), 32'h0);
        checkStatus("starveDone", 2'd0, 32'h0);
        nextCycle();

        // Reset mid-operation drops the buffered result
        applyStimulus(1'b1, 5'd24, 32'hD0, 1'b1, 5'd15, 32'hF);
        expectWrite(5'd24, 32'hD0);
        nextCycle();
        rst_i = 1'b1;
        applyStimulus(1'b1, 5'd25, 32'hD1, 1'b0, 5'd0, 32'h0);
        @(negedge clk_i);
        checkOutput("midRst.rfWe", 32'(rf_we_o), 32'h0);
        checkOutput("midRst.luReady", 32'(lu_ready_o), 32'h0);
        checkStatus("midRstBefore", 2'd1, 32'h8000);
        nextCycle();
        rst_i = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk_i);
        checkOutput("midRstAfter.rfWe", 32'(rf_we_o), 32'h0);
        checkStatus("midRstAfter", 2'd0, 32'h0);
        nextCycle();
        nextCycle();

        checkOutput("pendingWrites", 32'(expQ.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
